// File: rtl/hazard_scoreboard.sv
// Hazard detection and ID-stage forwarding: tracks in-flight destinations (E/M/W) with Tnew
// countdown, a mult/div busy counter and the ERET/EPC interlock. Macro: HAZARD_EX_FWD_EN.
module hazard_scoreboard #(
    parameter int unsigned NRP      = 2,
    parameter int unsigned DW       = 32,
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [NRP*5-1:0]  id_ra,
    input  logic [NRP*2-1:0]  id_tuse,
    input  logic [NRP*DW-1:0] id_rd,
    input  logic              id_we,
    input  logic [4:0]        id_wa,
    input  logic [1:0]        id_tnew,
    input  logic              id_md,
    input  logic              id_md_start,
    input  logic              id_md_div,
    input  logic              id_eret,
    input  logic              id_mtc0_epc,
    input  logic [DW-1:0]     ex_wd,
    input  logic [DW-1:0]     mem_wd,
    input  logic [DW-1:0]     wb_wd,
    input  logic              flush,
    output logic [NRP*DW-1:0] id_rd_fwd,
    output logic              stall,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_clr,
    output logic              md_busy
);

    typedef struct packed {
        logic       v;
        logic [4:0] a;
        logic [1:0] tn;
        logic       epc;
    } entry_t;

    localparam logic [7:0] L_MULT = 8'(MULT_CYC);
    localparam logic [7:0] L_DIV  = 8'(DIV_CYC);

    entry_t         r_e;
    entry_t         r_m;
    entry_t         r_w;
    logic [7:0]     r_md_cnt;

    logic           w_adv;
    logic           w_stall;
    logic [NRP-1:0] w_port_stall;
    logic           w_md_stall;
    logic           w_eret_stall;
    logic           w_e_gpr;

    function automatic logic [1:0] sat_dec(input logic [1:0] tn);
        return (tn == 2'd0) ? 2'd0 : tn - 2'd1;
    endfunction

    for (genvar k = 0; k < NRP; k++) begin : g_port
        logic [4:0]    w_ra;
        logic [1:0]    w_tuse;
        logic [DW-1:0] w_rd;
        logic          w_hit_e;
        logic          w_hit_m;
        logic          w_hit_w;
        logic [1:0]    w_tn_y;
        logic [DW-1:0] w_fwd;

        assign w_ra    = id_ra[5*k +: 5];
        assign w_tuse  = id_tuse[2*k +: 2];
        assign w_rd    = id_rd[DW*k +: DW];
        assign w_hit_e = r_e.v & (r_e.a == w_ra) & (w_ra != 5'd0);
        assign w_hit_m = r_m.v & (r_m.a == w_ra) & (w_ra != 5'd0);
        assign w_hit_w = r_w.v & (r_w.a == w_ra) & (w_ra != 5'd0);

        // Only the youngest matching producer decides; no match yields tn 0 (never stalls).
        always_comb begin
            w_tn_y = 2'd0;
            if (w_hit_e) begin
                w_tn_y = r_e.tn;
            end else if (w_hit_m) begin
                w_tn_y = r_m.tn;
            end else if (w_hit_w) begin
                w_tn_y = r_w.tn;
            end
        end

`ifdef HAZARD_EX_FWD_EN
        assign w_port_stall[k] = (w_tuse < w_tn_y);

        always_comb begin
            w_fwd = w_rd;
            if (w_ra == 5'd0) begin
                w_fwd = '0;
            end else if (w_hit_e && r_e.tn == 2'd0) begin
                w_fwd = ex_wd;
            end else if (w_hit_m && r_m.tn == 2'd0) begin
                w_fwd = mem_wd;
            end else if (w_hit_w && r_w.tn == 2'd0) begin
                w_fwd = wb_wd;
            end
        end
`else
        // Without the EX path a ready E result is picked up from M one cycle later.
        assign w_port_stall[k] = (w_tuse < w_tn_y) |
                                 (w_hit_e & (r_e.tn == 2'd0) & (w_tuse == 2'd0));

        always_comb begin
            w_fwd = w_rd;
            if (w_ra == 5'd0) begin
                w_fwd = '0;
            end else if (w_hit_m && r_m.tn == 2'd0) begin
                w_fwd = mem_wd;
            end else if (w_hit_w && r_w.tn == 2'd0) begin
                w_fwd = wb_wd;
            end
        end
`endif

        assign id_rd_fwd[DW*k +: DW] = w_fwd;
    end

`ifndef HAZARD_EX_FWD_EN
    logic w_unused_ex_wd;
    assign w_unused_ex_wd = ^ex_wd;
`endif

    logic w_unused_w_epc;
    assign w_unused_w_epc = r_w.epc;

    // A start loads the counter at EX entry, so a following mult/div user sees busy directly.
    assign w_md_stall   = id_md & md_busy;
    assign w_eret_stall = id_eret & ((r_e.v & r_e.epc) | (r_m.v & r_m.epc));
    assign w_stall      = id_valid & ((|w_port_stall) | w_md_stall | w_eret_stall);
    assign w_adv        = id_valid & ~w_stall & ~flush;

    // An EPC write occupies an entry even though it has no GPR destination.
    assign w_e_gpr = id_we & (id_wa != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e <= '0;
            r_m <= '0;
            r_w <= '0;
        end else if (flush) begin
            r_e.v <= 1'b0;
            r_m.v <= 1'b0;
            r_w.v <= 1'b0;
        end else begin
            r_e.v   <= w_adv & (w_e_gpr | id_mtc0_epc);
            r_e.a   <= id_we ? id_wa : 5'd0;
            r_e.tn  <= id_tnew;
            r_e.epc <= w_adv & id_mtc0_epc;
            r_m     <= '{v: r_e.v, a: r_e.a, tn: sat_dec(r_e.tn), epc: r_e.epc};
            r_w     <= '{v: r_m.v, a: r_m.a, tn: sat_dec(r_m.tn), epc: r_m.epc};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_md_cnt <= 8'd0;
        end else if (w_adv && id_md_start) begin
            r_md_cnt <= id_md_div ? L_DIV : L_MULT;
        end else if (r_md_cnt != 8'd0) begin
            r_md_cnt <= r_md_cnt - 8'd1;
        end
    end

    assign stall     = w_stall;
    assign pc_en     = ~w_stall;
    assign if_id_en  = ~w_stall;
    assign id_ex_clr = w_stall | flush;
    assign md_busy   = (r_md_cnt != 8'd0);

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and ID-stage forwarding unit for the five-stage MIPS pipeline. It keeps its own registered record of in-flight destination registers, with per-stage Tnew countdown, instead of taking stage Tnew values as inputs. It also owns an internal multiply/divide busy counter and the ERET/EPC interlock. It sits beside the ID/EX pipeline register and drives the PC, IF/ID and ID/EX control enables.

## Interface
Parameters:
- `NRP`, 2: number of ID read ports.
- `DW`, 32: data width.
- `MULT_CYC`, 5: busy cycles after a multiply starts.
- `DIV_CYC`, 10: busy cycles after a divide starts. Must be ≥ `MULT_CYC` and < 256.

Ports (clock and reset first):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_ra` in NRP*5: read addresses, packed; port k is `[5k+4:5k]`.
- `id_tuse` in NRP*2: Tuse per port, packed.
- `id_rd` in NRP*DW: register-file read data, packed.
- `id_we` in 1: ID instruction writes a GPR.
- `id_wa` in 5: its destination register.
- `id_tnew` in 2: cycles after EX entry until the result exists (0..3).
- `id_md` in 1: ID instruction uses the HI/LO/mult-div unit.
- `id_md_start` in 1: ID instruction starts a mult/div.
- `id_md_div` in 1: the start is a divide.
- `id_eret` in 1: ID holds ERET.
- `id_mtc0_epc` in 1: ID holds MTC0 to CP0 register 14.
- `ex_wd`, `mem_wd`, `wb_wd` in DW each: result data of each stage.
- `flush` in 1: exception/interrupt pipeline flush.
- `id_rd_fwd` out NRP*DW: forwarded read data.
- `stall` out 1.
- `pc_en`, `if_id_en` out 1 each: `!stall`.
- `id_ex_clr` out 1: `stall | flush`.
- `md_busy` out 1: busy counter ≠ 0.

## Operation
- Three registered entries E (EX), M (MEM), W (WB). Each entry holds `{v, a[4:0], tn[1:0], epc}`.
- Definition: `adv = id_valid & ~stall & ~flush`.
- Update at each posedge, in priority order:
  - On `flush`: all `v` ← 0.
  - Else:
    - E ← `{adv & id_we & id_wa≠0, id_wa, id_tnew, adv & id_mtc0_epc}`.
    - M ← E with `tn` = sat-dec(`tn`).
    - W ← M with `tn` = sat-dec(`tn`).
  - An entry with `epc` set is kept valid even when `a`=0.
- Match for port k at stage S: `S.v & S.a==id_ra[k] & id_ra[k]≠0`.
- Stall conditions (any one asserts `stall`; gated by `id_valid`):
  - A matching stage S with `id_tuse[k] < S.tn`. Only the youngest matching stage is considered (E over M over W).
  - `id_md & (md_busy | (E holds a start issued last cycle))`. This is realised as: counter loaded ⇒ busy the next cycle.
  - `id_eret & ((E.v & E.epc) | (M.v & M.epc))`.
- Forwarding for port k: `0` if `id_ra[k]`=0. Otherwise use the youngest matching stage with `tn`=0: E→`ex_wd`, M→`mem_wd`, W→`wb_wd`. With no such stage, use `id_rd[k]`.
- Consumers whose producer has `tn > 0` but `tuse ≥ tn` are not stalled. Their value is delivered by downstream stage forwarding, and `id_rd_fwd` is don't-care for them.
- Busy counter (8 bits):
  - Loads `DIV_CYC` or `MULT_CYC` when `adv & id_md_start`.
  - Otherwise decrements while nonzero.
  - `flush` suppresses a load in the same cycle but does not clear a running count.

## Timing
- Stall and forward are combinational from the registered entries plus ID inputs. Entries update one cycle after acceptance.
- Reset values:
  - All entries invalid; counter 0.
  - `stall`=0, `pc_en`=`if_id_en`=1, `id_ex_clr`=0, `md_busy`=0.
  - `id_rd_fwd` equals `id_rd` (0 for address 0).
- Back-to-back: a load (`tnew`=2) followed by a dependent `tuse`=0 instruction gives 2 stall cycles; `tuse`=1 gives 1 cycle.
- Simultaneous `flush` and `stall`: the flush wins; `id_ex_clr`=1 and entries clear.
- `reset` mid-busy: the counter clears immediately (asynchronously).
- Counter expiry: `md_busy` deasserts exactly N cycles after the start's EX-entry edge.

## Configuration
- `HAZARD_EX_FWD_EN` defined: the E stage with `tn`=0 forwards `ex_wd`, as above.
- Not defined: the E stage never forwards. A match at E with `tn`=0 and `tuse`=0 stalls one cycle and the value comes from M. `ex_wd` is unused.

## Test plan
- ADDU $3 (`tnew` 1), then BEQ on $3 (`tuse` 0): 1 stall cycle, then `id_rd_fwd[0]` = `mem_wd` (0x1234).
- LW $5 (`tnew` 2), then ADDU on $5 (`tuse` 1): exactly 1 stall cycle; no stall with an independent register. Writes to $0 never stall, and forward 0.
- MULT, then MFHI immediately: stalls `MULT_CYC` cycles after the start is accepted. DIV gives `DIV_CYC` cycles. A reset at cycle 3 of DIV drops `md_busy` at once.
- MTC0 EPC, then ERET: ERET stalls while the MTC0 is in E or M, and releases when it reaches W.
- `flush` while a dependent load is stalling: entries clear, `stall`=0 the next cycle, `id_ex_clr`=1 in the flush cycle.
- JAL (`tnew` 0), then JR $31 (`tuse` 0): no stall with `HAZARD_EX_FWD_EN` (`ex_wd` forwarded); 1 stall cycle without it.
